oram_req_arbiter: RTL

ORAM_REQ_ARBITER -- requirements
Module: oram_req_arbiter

---
 rtl/oram_functions_pkg.sv | 16 +
 rtl/oram_rr_arbiter.sv | 30 +++
 rtl/oram_req_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/oram_functions_pkg.sv
// Shared ORAM definitions: tree/block geometry and the request-arbiter state type.
package oram_functions_pkg;

   localparam int unsigned TREE_DEPTH      = 8;
   localparam int unsigned BYTE_WIDTH      = 8;
   localparam int unsigned BYTES_PER_BLOCK = 2;
   localparam int unsigned DATA_W          = BYTE_WIDTH * BYTES_PER_BLOCK;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } oram_arb_state_t;

endpackage

// File: rtl/oram_rr_arbiter.sv
// Round-robin grant: one-hot grant on the first asserted request at or after ptr.
module oram_rr_arbiter #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   winner
);

   // Walk the requesters starting at ptr, wrapping, and take the first valid one.
   always_comb begin : pick
      int unsigned idx;
      logic        found;
      grant  = '0;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(ptr) + k) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            winner     = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/oram_req_arbiter.sv
// Shares one ORAM core among NUM_REQ requesters: round-robin accept, issue one
// operation to the core, wait for its result, then strobe the response back.
// Optional WAIT watchdog enabled by defining ORAM_ARB_TIMEOUT_EN.
module oram_req_arbiter
   import oram_functions_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_rw,
   input  logic [NUM_REQ*TREE_DEPTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DATA_W-1:0]             resp_rdata,
   output logic                          resp_err,
   output logic [TREE_DEPTH-1:0]         core_block_number,
   output logic [DATA_W-1:0]             core_w_value,
   output logic                          core_rw,
   output logic                          core_input_ready,
   input  logic [DATA_W-1:0]             core_r_value,
   input  logic                          core_output_ready,
   output logic                          busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("oram_req_arbiter: NUM_REQ must be in 2..8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("oram_req_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   oram_arb_state_t      state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, winner_q, winner, ptr_next;
   logic [NUM_REQ-1:0]   grant;
   logic [DATA_W-1:0]    rdata_q;
   logic                 accept;
   logic                 err_flag;
   logic                 timeout_hit;

   oram_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_valid (req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .winner    (winner)
   );

   assign accept   = (state_q == IDLE) && (|grant);
   assign ptr_next = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

`ifdef ORAM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign err_flag    = err_q;

   // Watchdog: cleared while in ISSUE (i.e. on WAIT entry), counts WAIT cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  wait_cnt <= '0;
      else if (state_q == ISSUE)   wait_cnt <= '0;
      else if (state_q == WAIT)    wait_cnt <= wait_cnt + 1'b1;
   end

   // Error flag: set when the watchdog expires, cleared on each new acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if (accept)
         err_q <= 1'b0;
      else if (state_q == WAIT && !core_output_ready && timeout_hit)
         err_q <= 1'b1;
   end
`else
   assign timeout_hit = 1'b0;
   assign err_flag    = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (core_output_ready || timeout_hit) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request capture on acceptance, plus read-data capture from the core.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q             <= '0;
         winner_q          <= '0;
         core_block_number <= '0;
         core_w_value      <= '0;
         core_rw           <= 1'b0;
         rdata_q           <= '0;
      end else begin
         if (accept) begin
            ptr_q             <= ptr_next;
            winner_q          <= winner;
            core_block_number <= req_addr[int'(winner)*TREE_DEPTH +: TREE_DEPTH];
            core_w_value      <= req_wdata[int'(winner)*DATA_W +: DATA_W];
            core_rw           <= req_rw[winner];
            rdata_q           <= '0;
         end
         if (state_q == WAIT && core_output_ready)
            rdata_q <= core_r_value;
      end
   end

   // req_ready is combinational from req_valid, so it is also masked while reset is held.
   assign req_ready        = (state_q == IDLE && rst_n) ? grant : '0;
   assign core_input_ready = (state_q == ISSUE);
   assign resp_valid       = (state_q == RESP) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << winner_q) : '0;
   assign resp_rdata       = (state_q == RESP && !core_rw && !err_flag) ? rdata_q : '0;
   assign resp_err         = (state_q == RESP) && err_flag;
   assign busy             = (state_q != IDLE);

endmodule
